// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the core's fetch/load-store ports and the unified memory.
// The slave modport is the arbiter's view; master is the core-plus-memory environment.
interface mem_arbiter_if #(
    parameter int unsigned data_width    = 32,
    parameter int unsigned address_width = 32
);
    logic                       i_req;
    logic [address_width-1:0]   i_addr;
    logic                       i_ack;
    logic [data_width-1:0]      i_rdata;
    logic                       i_err;

    logic                       d_req;
    logic                       d_we;
    logic [address_width-1:0]   d_addr;
    logic [data_width-1:0]      d_wdata;
    logic [data_width/8-1:0]    d_byte_we;
    logic                       d_ack;
    logic [data_width-1:0]      d_rdata;
    logic                       d_err;

    logic [address_width-1:0]   mem_address;
    logic [data_width-1:0]      mem_data_in;
    logic                       mem_read_write;
    logic                       mem_enable;
    logic [data_width/8-1:0]    mem_byte_we;
    logic [data_width-1:0]      mem_data_out;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_byte_we, mem_data_out,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        output mem_address, mem_data_in, mem_read_write, mem_enable, mem_byte_we
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_byte_we, mem_data_out,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        input  mem_address, mem_data_in, mem_read_write, mem_enable, mem_byte_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and data
// ports: IDLE -> ACCESS -> DONE per transaction, with range/alignment errors that skip memory.
module mem_arbiter #(
    parameter int unsigned              data_width     = 32,
    parameter int unsigned              address_width  = 32,
    parameter logic [address_width-1:0] base_address   = 32'h80020000,
    parameter int unsigned              mem_size_bytes = 1048576
) (
    input logic           clock,
    input logic           reset_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [address_width-1:0] mem_limit = address_width'(mem_size_bytes);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e state;
    logic   owner_is_d;
    logic   last_grant_d;
    logic   err_flag;

    logic                     grant;
    logic                     grant_d;
    logic                     grant_err;
    logic [address_width-1:0] grant_addr;
    logic [address_width-1:0] grant_offset;

    // In DONE only the non-owner may be granted; the owner's still-high req is ignored.
    always_comb begin
        grant   = 1'b0;
        grant_d = 1'b0;
        case (state)
            StIdle: begin
                grant   = bus.i_req | bus.d_req;
                grant_d = (bus.i_req && bus.d_req) ? ~last_grant_d : bus.d_req;
            end
            StDone: begin
                grant   = owner_is_d ? bus.i_req : bus.d_req;
                grant_d = ~owner_is_d;
            end
            default: ;
        endcase
        grant_addr   = grant_d ? bus.d_addr : bus.i_addr;
        grant_offset = grant_addr - base_address;
        grant_err    = (grant_addr < base_address) || (grant_offset >= mem_limit) ||
                       (grant_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= StIdle;
            owner_is_d         <= 1'b0;
            last_grant_d       <= 1'b1;
            err_flag           <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_data_in    <= '0;
            bus.mem_byte_we    <= '0;
            bus.mem_read_write <= 1'b1;
            bus.mem_enable     <= 1'b0;
            bus.i_ack          <= 1'b0;
            bus.i_err          <= 1'b0;
            bus.i_rdata        <= '0;
            bus.d_ack          <= 1'b0;
            bus.d_err          <= 1'b0;
            bus.d_rdata        <= '0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    bus.i_ack <= 1'b0;
                    bus.i_err <= 1'b0;
                    bus.d_ack <= 1'b0;
                    bus.d_err <= 1'b0;
                    if (grant) begin
                        state              <= StAccess;
                        owner_is_d         <= grant_d;
                        last_grant_d       <= grant_d;
                        err_flag           <= grant_err;
                        bus.mem_address    <= grant_addr;
                        bus.mem_data_in    <= grant_d ? bus.d_wdata : '0;
                        bus.mem_byte_we    <= (grant_d && bus.d_we) ? bus.d_byte_we : '0;
                        bus.mem_read_write <= grant_d ? ~bus.d_we : 1'b1;
                        bus.mem_enable     <= ~grant_err;
                    end else begin
                        state <= StIdle;
                    end
                end
                StAccess: begin
                    state              <= StDone;
                    bus.mem_enable     <= 1'b0;
                    bus.mem_read_write <= 1'b1;
                    bus.mem_byte_we    <= '0;
                    // mem_read_write still holds this access's direction at the closing edge.
                    if (owner_is_d) begin
                        bus.d_ack <= 1'b1;
                        bus.d_err <= err_flag;
                        if (err_flag) begin
                            bus.d_rdata <= '0;
                        end else if (bus.mem_read_write) begin
                            bus.d_rdata <= bus.mem_data_out;
                        end
                    end else begin
                        bus.i_ack   <= 1'b1;
                        bus.i_err   <= err_flag;
                        bus.i_rdata <= err_flag ? '0 : bus.mem_data_out;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions against a small
// memory model, plus sequences for alternation, same-port re-request and reset mid-access.
module tb_mem_arbiter;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter_if #(.data_width(32), .address_width(32)) bus ();

    mem_arbiter #(
        .data_width    (32),
        .address_width (32),
        .base_address  (32'h80020000),
        .mem_size_bytes(1048576)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Memory model: 64 words aliased over the window; a marker value when disabled.
    logic [31:0] mem [64];
    assign bus.mem_data_out = bus.mem_enable ? mem[bus.mem_address[7:2]] : 32'hBAD0BAD0;

    always @(posedge clock) begin
        if (bus.mem_enable && !bus.mem_read_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_byte_we[b]) mem[bus.mem_address[7:2]][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
            end
        end
    end

    // Cumulative activity counters, sampled mid-cycle.
    int          en_cnt    = 0;
    int          i_ack_cnt = 0;
    int          d_ack_cnt = 0;
    logic [31:0] en_addr;
    logic        en_rw;
    logic [3:0]  en_be;

    always @(negedge clock) begin
        if (bus.mem_enable) begin
            en_cnt  = en_cnt + 1;
            en_addr = bus.mem_address;
            en_rw   = bus.mem_read_write;
            en_be   = bus.mem_byte_we;
        end
        if (bus.i_ack) i_ack_cnt = i_ack_cnt + 1;
        if (bus.d_ack) d_ack_cnt = d_ack_cnt + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic run_txn(input vec_t v, input int idx);
        int   e0, ia0, da0, lat;
        logic got;
        e0  = en_cnt;
        ia0 = i_ack_cnt;
        da0 = d_ack_cnt;
        @(negedge clock);
        if (v.is_d) begin
            bus.d_we      = v.we;
            bus.d_addr    = v.addr;
            bus.d_wdata   = v.wdata;
            bus.d_byte_we = v.be;
            bus.d_req     = 1'b1;
        end else begin
            bus.i_addr = v.addr;
            bus.i_req  = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(posedge clock);
            #1;
            if (v.is_d ? bus.d_ack : bus.i_ack) begin
                got = 1'b1;
                lat = k;
            end
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'd2);
        check($sformatf("v%0d rdata", idx), v.is_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
        check($sformatf("v%0d err", idx), {31'b0, v.is_d ? bus.d_err : bus.i_err},
              {31'b0, v.exp_err});
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check($sformatf("v%0d enable cycles", idx), 32'(en_cnt - e0), v.exp_err ? 32'd0 : 32'd1);
        if (!v.exp_err) begin
            check($sformatf("v%0d mem addr", idx), en_addr, v.addr);
            check($sformatf("v%0d mem rw", idx), {31'b0, en_rw}, {31'b0, ~(v.is_d & v.we)});
            check($sformatf("v%0d mem be", idx), {28'b0, en_be},
                  {28'b0, (v.is_d && v.we) ? v.be : 4'h0});
        end
        check($sformatf("v%0d own acks", idx), 32'(v.is_d ? d_ack_cnt - da0 : i_ack_cnt - ia0), 32'd1);
        check($sformatf("v%0d other acks", idx), 32'(v.is_d ? i_ack_cnt - ia0 : d_ack_cnt - da0),
              32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int   i_e[2];
        int   d_e[2];
        int   ni, nd, i_left, d_left, da0;
        vec_t tmp;

        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_byte_we = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5000000 | 32'(i);
        mem[0] = 32'h24080005;
        mem[4] = 32'h11223344;
        mem[8] = 32'hCAFEF00D;

        //          is_d  we    addr          wdata         be     exp_rdata     err
        vecs[0]  = '{1'b0, 1'b0, 32'h80020000, 32'h0,        4'h0, 32'h24080005, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h80020010, 32'hDEADBEEF, 4'h3, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h80020010, 32'h0,        4'h0, 32'h1122BEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h80020018, 32'h55667788, 4'hF, 32'h1122BEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h80020018, 32'h0,        4'h0, 32'h55667788, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h80020002, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h80120000, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'h8001FFFC, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 32'h80020011, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h80020010, 32'h0,        4'h0, 32'h1122BEEF, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h80020003, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h80020018, 32'h0,        4'h0, 32'h55667788, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h8011FFFC, 32'h0,        4'h0, 32'hA500003F, 1'b0};

        // Reset state while reset is held.
        #12;
        check("rst mem_enable", {31'b0, bus.mem_enable}, 32'd0);
        check("rst mem_read_write", {31'b0, bus.mem_read_write}, 32'd1);
        check("rst mem_address", bus.mem_address, 32'h0);
        check("rst acks", {30'b0, bus.i_ack, bus.d_ack}, 32'd0);
        check("rst rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int v = 0; v < 13; v++) run_txn(vecs[v], v);
        check("err write left memory", mem[4], 32'h1122BEEF);

        // Both ports held requesting: grants alternate I, D, I, D with acks two cycles apart.
        @(negedge clock);
        bus.i_addr = 32'h80020000;
        bus.d_addr = 32'h80020010;
        bus.d_we   = 1'b0;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        ni = 0; nd = 0; i_left = 2; d_left = 2;
        i_e[0] = -1; i_e[1] = -1; d_e[0] = -1; d_e[1] = -1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clock);
            #1;
            if (bus.i_ack) begin
                if (ni < 2) i_e[ni] = e;
                ni++;
                check("alt i_rdata", bus.i_rdata, 32'h24080005);
                bus.i_req = 1'b0;
                i_left--;
            end else if (!bus.i_req && i_left > 0) begin
                bus.i_req = 1'b1;
            end
            if (bus.d_ack) begin
                if (nd < 2) d_e[nd] = e;
                nd++;
                check("alt d_rdata", bus.d_rdata, 32'h1122BEEF);
                bus.d_req = 1'b0;
                d_left--;
            end else if (!bus.d_req && d_left > 0) begin
                bus.d_req = 1'b1;
            end
        end
        check("alt i ack#1 edge", 32'(i_e[0]), 32'd2);
        check("alt d ack#1 edge", 32'(d_e[0]), 32'd4);
        check("alt i ack#2 edge", 32'(i_e[1]), 32'd6);
        check("alt d ack#2 edge", 32'(d_e[1]), 32'd8);

        // Lone port holding req: DONE -> IDLE -> ACCESS gives three cycles per transaction.
        @(negedge clock);
        bus.i_addr = 32'h80020000;
        bus.i_req  = 1'b1;
        ni = 0;
        i_e[0] = -1; i_e[1] = -1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clock);
            #1;
            if (bus.i_ack) begin
                if (ni < 2) i_e[ni] = e;
                ni++;
                if (ni >= 2) bus.i_req = 1'b0;
            end
        end
        check("same-port ack#1 edge", 32'(i_e[0]), 32'd2);
        check("same-port ack#2 edge", 32'(i_e[1]), 32'd5);

        // Reset asserted during the ACCESS cycle of a write.
        da0 = d_ack_cnt;
        @(negedge clock);
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h80020020;
        bus.d_wdata   = 32'h00000000;
        bus.d_byte_we = 4'hF;
        bus.d_req     = 1'b1;
        @(posedge clock);
        #1;
        check("mid-rst enable before", {31'b0, bus.mem_enable}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid-rst enable async drop", {31'b0, bus.mem_enable}, 32'd0);
        check("mid-rst mem_read_write", {31'b0, bus.mem_read_write}, 32'd1);
        check("mid-rst rdata cleared", bus.i_rdata | bus.d_rdata, 32'h0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("mid-rst no ack", 32'(d_ack_cnt - da0), 32'd0);
        check("mid-rst memory kept", mem[8], 32'hCAFEF00D);
        tmp = '{1'b0, 1'b0, 32'h80020020, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0};
        run_txn(tmp, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-ported unified memory between the instruction-fetch port and the load/store data port of the MIPS core. Fixed 3-state access sequence per transaction, round-robin between ports, registered memory-side outputs, registered read data, and an address range/alignment check that returns an error instead of touching memory. Sits between the core's fetch/MEM stages and the memory block.

## Interface
- data_width, 32, data bus width (multiple of 8)
- address_width, 32, address bus width
- base_address, 32'h80020000, first byte address of memory window
- mem_size_bytes, 1048576, window size in bytes; valid range [base_address, base_address+mem_size_bytes)
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request; hold until i_ack
- i_addr  in  address_width  fetch byte address
- i_ack  out  1  one-cycle completion pulse
- i_rdata  out  data_width  fetched word, valid with i_ack, held until next i_ack
- i_err  out  1  with i_ack: address out of range or misaligned
- d_req  in  1  data request; hold with all d_* stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  address_width  data byte address
- d_wdata  in  data_width  write data
- d_byte_we  in  data_width/8  per-byte write enables (writes only)
- d_ack, d_rdata, d_err  out  1 / data_width / 1  as for i_ port
- mem_address  out  address_width  to memory
- mem_data_in  out  data_width  to memory
- mem_read_write  out  1  1 = read, 0 = write
- mem_enable  out  1  memory enable
- mem_byte_we  out  data_width/8  byte enables to memory
- mem_data_out  in  data_width  combinational read data (high-Z when not enabled)

## Operation
- States: IDLE, ACCESS, DONE. Registers: state, owner (I/D), last_grant, err_flag, rdata regs per port.
- IDLE: if any req, grant per round-robin and go ACCESS; else stay.
- Round-robin: both requesting -> grant port not equal last_grant; single request -> grant it. last_grant updated on every grant.
- On grant, capture into mem_* registers: address, wdata, byte_we, mem_read_write = ~d_we for D, 1 for I; byte_we forced 0 for reads and I grants.
- Check on grant: err if addr < base_address, addr - base_address >= mem_size_bytes, or addr[1:0] != 0. Err -> mem_enable stays 0 in ACCESS; otherwise mem_enable = 1 for exactly the ACCESS cycle.
- ACCESS: always -> DONE. At closing edge: read -> owner rdata <= mem_data_out (or 0 if err); write committed by memory on same edge; rdata of owner unchanged on write (0 loaded on err).
- DONE: owner ack = 1, owner err = err_flag. mem_enable = 0, mem_read_write = 1. Owner's req is ignored this cycle (requester drops it after ack). If other port requests -> grant it, go ACCESS; else IDLE.
- Non-owner ack/err always 0.

## Timing
- Reset (async, immediate): state IDLE, last_grant = D (I wins first tie), mem_enable 0, mem_read_write 1, mem_address/mem_data_in/mem_byte_we 0, i_ack/d_ack/i_err/d_err 0, i_rdata/d_rdata 0.
- Latency: req seen at edge N -> ACCESS in cycle N..N+1 -> ack high cycle N+1..N+2. Two cycles req-to-ack from IDLE.
- Back-to-back alternating ports: one transaction every 2 cycles (DONE -> ACCESS direct).
- Same port re-requesting with no competitor: req sampled low in IDLE path, so 3 cycles per transaction (DONE -> IDLE -> ACCESS).
- Reset mid-ACCESS: mem_enable drops asynchronously; no write occurs; no ack issued.
- Requester changing signals before ack: undefined, not supported.

## Test plan
- Reset then i_req, i_addr=32'h80020000, memory holds 32'h24080005 -> mem_enable high one cycle with mem_read_write=1, i_ack pulse 2 cycles after req, i_rdata=32'h24080005, i_err=0.
- d_req write d_addr=32'h80020010, d_wdata=32'hDEADBEEF, d_byte_we=4'b0011 over word 32'h11223344 -> d_ack after 2 cycles, following D read returns 32'h1122BEEF.
- i_req and d_req asserted same cycle after reset, held -> I granted first, D granted in I's DONE cycle, acks 2 cycles apart; repeat -> D then I (alternation).
- d_addr=32'h80020002 and separately 32'h80120000 and 32'h8001FFFC -> mem_enable never asserts, d_ack with d_err=1, d_rdata=0, memory unchanged.
- Assert reset_n low during ACCESS of a write to 32'h80020020 -> mem_enable 0 immediately, no ack, location keeps old value, state IDLE after release.
